// File: rtl/bram_pixel_stream_in.sv
// Streams the nine per-direction lattice BRAMs out as one 144-bit AXI-Stream beat per pixel.
// A two-entry skid buffer absorbs the one-cycle BRAM read latency so beats can flow every cycle.
module bram_pixel_stream_in #(
    parameter int DATA_WIDTH    = 16,
    parameter int DEPTH         = 2500,
    parameter int ADDRESS_WIDTH = 12
) (
    input  logic                      m00_axis_aclk,
    input  logic                      m00_axis_aresetn,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      ren,
    output logic [ADDRESS_WIDTH-1:0]  read_addr,
    input  logic [DATA_WIDTH-1:0]     n,
    // `null` is a reserved word, so that lane's port carries a suffix
    input  logic [DATA_WIDTH-1:0]     null_dir,
    input  logic [DATA_WIDTH-1:0]     ne,
    input  logic [DATA_WIDTH-1:0]     e,
    input  logic [DATA_WIDTH-1:0]     se,
    input  logic [DATA_WIDTH-1:0]     s,
    input  logic [DATA_WIDTH-1:0]     sw,
    input  logic [DATA_WIDTH-1:0]     w,
    input  logic [DATA_WIDTH-1:0]     nw,
    output logic                      m00_axis_tvalid,
    output logic [9*DATA_WIDTH-1:0]   m00_axis_tdata,
    output logic [9*DATA_WIDTH/8-1:0] m00_axis_tstrb,
    output logic                      m00_axis_tlast,
    input  logic                      m00_axis_tready
);
    localparam int BEAT_W = 9 * DATA_WIDTH;
    localparam logic [ADDRESS_WIDTH-1:0] DEPTH_A = ADDRESS_WIDTH'(DEPTH);
    localparam logic [ADDRESS_WIDTH-1:0] LAST_A  = ADDRESS_WIDTH'(DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic [ADDRESS_WIDTH-1:0]   r_issue_cnt;
    logic                       r_rd_pending;
    logic                       r_pend_last;
    logic [BEAT_W-1:0]          r_buf_data [2];
    logic [1:0]                 r_buf_last;
    logic                       r_head;
    logic [1:0]                 r_occ;
    logic                       w_pop;
    logic                       w_ren;
    logic                       w_tail;
    logic [2:0]                 w_fill;
    logic [BEAT_W-1:0]          w_beat;

    assign w_beat = {nw, w, sw, s, se, e, ne, null_dir, n};
    assign w_pop  = m00_axis_tvalid && m00_axis_tready;
    // Occupancy the buffer will have next cycle, counting the read already in flight
    assign w_fill = {1'b0, r_occ} + {2'b00, r_rd_pending} - {2'b00, w_pop};
    assign w_ren  = (r_state == S_RUN) && (r_issue_cnt < DEPTH_A) && (w_fill < 3'd2);
    assign w_tail = r_head ^ r_occ[0];

    assign ren             = w_ren;
    assign read_addr       = r_issue_cnt;
    assign busy            = (r_state == S_RUN);
    assign done            = (r_state == S_DONE);
    assign m00_axis_tvalid = (r_occ != 2'd0);
    assign m00_axis_tdata  = r_buf_data[r_head];
    assign m00_axis_tlast  = r_buf_last[r_head];
    assign m00_axis_tstrb  = '1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_pop && m00_axis_tlast) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_state      <= S_IDLE;
            r_issue_cnt  <= '0;
            r_rd_pending <= 1'b0;
            r_pend_last  <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_rd_pending <= w_ren;
            r_pend_last  <= w_ren && (r_issue_cnt == LAST_A);
            if ((r_state == S_IDLE) && start)
                r_issue_cnt <= '0;
            else if (w_ren)
                r_issue_cnt <= r_issue_cnt + ADDRESS_WIDTH'(1);
        end
    end

    // The issue rule guarantees a capture never lands on a full buffer
    always_ff @(posedge m00_axis_aclk or negedge m00_axis_aresetn) begin
        if (!m00_axis_aresetn) begin
            r_buf_data[0] <= '0;
            r_buf_data[1] <= '0;
            r_buf_last    <= 2'b00;
            r_head        <= 1'b0;
            r_occ         <= 2'd0;
        end else begin
            if (r_rd_pending) begin
                r_buf_data[w_tail] <= w_beat;
                r_buf_last[w_tail] <= r_pend_last;
            end
            if (w_pop)
                r_head <= ~r_head;
            case ({r_rd_pending, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_pixel_stream_in.sv
// Directed bench for bram_pixel_stream_in: BRAM model returns the address in every lane,
// a negedge monitor checks beat order, tlast, done timing and AXIS stability.
module tb_bram_pixel_stream_in;
    localparam int DW    = 16;
    localparam int DEPTH = 2500;
    localparam int AW    = 12;
    localparam int BW    = 144;
    localparam logic [BW-1:0] PACK = 144'h9999_8888_7777_6666_5555_4444_3333_2222_1111;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          tready = 1'b0;
    logic          pack_mode = 1'b0;
    logic          busy, done, ren, tvalid, tlast;
    logic [AW-1:0] read_addr;
    logic [BW-1:0] tdata;
    logic [17:0]   tstrb;
    logic [AW-1:0] bram_q = '0;
    logic [DW-1:0] lane [9];

    int pass_cnt = 0;
    int total_cnt = 0;
    int hs_total = 0;
    int tlast_total = 0;
    int done_total = 0;

    always #5 clk = ~clk;

    bram_pixel_stream_in #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDRESS_WIDTH(AW)) dut (
        .m00_axis_aclk(clk), .m00_axis_aresetn(rst_n), .start(start),
        .busy(busy), .done(done), .ren(ren), .read_addr(read_addr),
        .n(lane[0]), .null_dir(lane[1]), .ne(lane[2]), .e(lane[3]), .se(lane[4]),
        .s(lane[5]), .sw(lane[6]), .w(lane[7]), .nw(lane[8]),
        .m00_axis_tvalid(tvalid), .m00_axis_tdata(tdata), .m00_axis_tstrb(tstrb),
        .m00_axis_tlast(tlast), .m00_axis_tready(tready)
    );

    always @(posedge clk) if (ren) bram_q <= read_addr;

    always_comb begin
        for (int i = 0; i < 9; i++)
            lane[i] = (pack_mode && bram_q == '0) ? DW'(16'h1111 * (i + 1)) : DW'(bram_q);
    end

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    function automatic logic [BW-1:0] exp_beat(input int k);
        logic [DW-1:0] v;
        v = DW'(k);
        if (pack_mode && k == 0) return PACK;
        return {9{v}};
    endfunction

    initial begin : monitor
        int k;
        logic prev_stall, prev_last_hs, prev_tlast;
        logic [BW-1:0] prev_data;
        k = 0; prev_stall = 0; prev_last_hs = 0; prev_tlast = 0; prev_data = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                k = 0; prev_stall = 0; prev_last_hs = 0;
            end else begin
                if (prev_stall) begin
                    check("stall_tvalid", tvalid, 1'b1);
                    check("stall_tdata", tdata, prev_data);
                    check("stall_tlast", tlast, prev_tlast);
                end
                if (done) begin
                    done_total++;
                    check("done_after_tlast", prev_last_hs, 1'b1);
                end
                prev_last_hs = 1'b0;
                if (tvalid && tready) begin
                    check("beat_data", tdata, exp_beat(k));
                    check("beat_tlast", tlast, (k == DEPTH - 1));
                    hs_total++;
                    if (tlast) tlast_total++;
                    prev_last_hs = tlast;
                    k = tlast ? 0 : k + 1;
                end
                prev_stall = tvalid && !tready;
                prev_data  = tdata;
                prev_tlast = tlast;
            end
        end
    end

    task automatic start_pulse();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // mode 0: tready held 1; mode 1: random tready. glitch_at >= 0 pulses start after that many beats.
    task automatic wait_frame(input int mode, input int glitch_at, output int cycles);
        int  base;
        bit  glitched;
        base = hs_total; glitched = 0; cycles = 0;
        while (!done && cycles < 4 * DEPTH) begin
            tready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            start  = (glitch_at >= 0 && !glitched && (hs_total - base) == glitch_at);
            if (start) glitched = 1;
            @(posedge clk); #1;
            cycles++;
        end
        start  = 1'b0;
        tready = 1'b1;
        check("frame_done_seen", done, 1'b1);
    endtask

    task automatic finish_frame(input string tag, input int hs0, input int tl0, input int dn0);
        repeat (3) begin @(posedge clk); #1; end
        check({tag, "_beats"}, BW'(hs_total - hs0), BW'(DEPTH));
        check({tag, "_tlasts"}, BW'(tlast_total - tl0), BW'(1));
        check({tag, "_dones"}, BW'(done_total - dn0), BW'(1));
        check({tag, "_busy_low"}, busy, 1'b0);
        check({tag, "_tvalid_low"}, tvalid, 1'b0);
        check({tag, "_addr_hold"}, read_addr, BW'(DEPTH));
    endtask

    typedef struct {
        logic          tr;
        logic          ren;
        logic [AW-1:0] addr;
        logic          tv;
        bit            chk_data;
        int            beat;
    } vec_t;

    initial begin : main
        vec_t tbl [13];
        int   hs0, tl0, dn0, cyc, budget;

        tbl[0]  = '{1'b0, 1'b1, 12'd0, 1'b0, 1'b0, 0};
        tbl[1]  = '{1'b0, 1'b1, 12'd1, 1'b0, 1'b0, 0};
        for (int i = 2; i < 10; i++) tbl[i] = '{1'b0, 1'b0, 12'd2, 1'b1, 1'b1, 0};
        tbl[10] = '{1'b1, 1'b1, 12'd2, 1'b1, 1'b1, 0};
        tbl[11] = '{1'b1, 1'b1, 12'd3, 1'b1, 1'b1, 1};
        tbl[12] = '{1'b1, 1'b1, 12'd4, 1'b1, 1'b1, 2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_ren", ren, 1'b0);
        check("rst_addr", read_addr, '0);
        check("rst_tvalid", tvalid, 1'b0);
        check("rst_tlast", tlast, 1'b0);
        check("rst_tdata", tdata, '0);
        check("tstrb", tstrb, 18'h3FFFF);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // Frame 1: lane packing, start latency and full-rate throughput
        pack_mode = 1'b1; tready = 1'b1;
        hs0 = hs_total; tl0 = tlast_total; dn0 = done_total;
        start_pulse();
        check("lat1_tvalid", tvalid, 1'b0);
        check("lat1_ren", ren, 1'b1);
        check("lat1_addr", read_addr, '0);
        check("lat1_busy", busy, 1'b1);
        @(posedge clk); #1;
        check("lat2_tvalid", tvalid, 1'b0);
        check("lat2_addr", read_addr, BW'(1));
        @(posedge clk); #1;
        check("lat3_tvalid", tvalid, 1'b1);
        check("pack_tdata", tdata, PACK);
        check("pack_tlast", tlast, 1'b0);
        wait_frame(0, -1, cyc);
        check("throughput_cycles", BW'(cyc), BW'(DEPTH));
        finish_frame("full", hs0, tl0, dn0);
        pack_mode = 1'b0;

        // Frame 2: backpressure from start, table-driven
        tready = 1'b0;
        hs0 = hs_total; tl0 = tlast_total; dn0 = done_total;
        start_pulse();
        for (int i = 0; i < 13; i++) begin
            tready = tbl[i].tr;
            @(negedge clk);
            check($sformatf("bp%0d_ren", i), ren, tbl[i].ren);
            check($sformatf("bp%0d_addr", i), read_addr, tbl[i].addr);
            check($sformatf("bp%0d_tvalid", i), tvalid, tbl[i].tv);
            if (tbl[i].chk_data)
                check($sformatf("bp%0d_tdata", i), tdata, exp_beat(tbl[i].beat));
            @(posedge clk); #1;
        end
        wait_frame(0, -1, cyc);
        finish_frame("bp", hs0, tl0, dn0);

        // Frame 3: random tready
        hs0 = hs_total; tl0 = tlast_total; dn0 = done_total;
        start_pulse();
        wait_frame(1, -1, cyc);
        finish_frame("rand", hs0, tl0, dn0);

        // Frame 4: start pulsed mid-frame must be ignored
        hs0 = hs_total; tl0 = tlast_total; dn0 = done_total;
        start_pulse();
        wait_frame(0, 100, cyc);
        finish_frame("glitch", hs0, tl0, dn0);

        // Frame 5: reset at beat 1000, then a clean frame from address 0
        hs0 = hs_total; dn0 = done_total;
        start_pulse();
        budget = 0;
        while ((hs_total - hs0) < 1000 && budget < 4 * DEPTH) begin
            @(posedge clk); #1;
            budget++;
        end
        check("rst_mid_reached", BW'(hs_total - hs0), BW'(1000));
        rst_n = 1'b0;
        #1;
        check("rstm_tvalid", tvalid, 1'b0);
        check("rstm_busy", busy, 1'b0);
        check("rstm_ren", ren, 1'b0);
        check("rstm_addr", read_addr, '0);
        check("rstm_tlast", tlast, 1'b0);
        @(negedge clk);
        @(posedge clk); #3;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rstm_no_done", BW'(done_total - dn0), BW'(0));
        hs0 = hs_total; tl0 = tlast_total; dn0 = done_total;
        start_pulse();
        wait_frame(0, -1, cyc);
        finish_frame("after_rst", hs0, tl0, dn0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule

// File: doc/bram_pixel_stream_in.md
Name: bram_pixel_stream_in

Overview:
Reads the nine per-direction lattice BRAMs pixel by pixel and streams each pixel as one 144-bit AXI-Stream beat toward DDR. It is the transmit-side counterpart of the DDR-to-BRAM pixel receiver and uses the same lane packing. One frame is DEPTH beats, with tlast on the final beat. A 2-entry output buffer hides the 1-cycle BRAM read latency, so the block sustains 1 beat/cycle under continuous tready.

Parameters:
DATA_WIDTH, 16, width of one direction value
DEPTH, 2500, pixels per frame (beats per packet)
ADDRESS_WIDTH, 12, BRAM address width

Ports:
m00_axis_aclk  in  1  sole clock
m00_axis_aresetn  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse; begins one frame, honoured only in IDLE
busy  out  1  high in RUN
done  out  1  one-cycle pulse after the tlast handshake
ren  out  1  BRAM read enable, shared by all nine BRAMs
read_addr  out  ADDRESS_WIDTH  BRAM read address
n, null, ne, e, se, s, sw, w, nw  in  DATA_WIDTH each  BRAM read data, valid the cycle after ren
m00_axis_tvalid  out  1  AXIS valid
m00_axis_tdata  out  144  packed pixel
m00_axis_tstrb  out  18  constant all ones
m00_axis_tlast  out  1  last beat of frame
m00_axis_tready  in  1  AXIS ready

Behaviour:
- Reset (async, immediate):
  - state=IDLE
  - busy=0, done=0, ren=0, read_addr=0, issue_cnt=0
  - buffer empty, rd_pending=0
  - tvalid=0, tlast=0, tdata=0
- Reset mid-frame: the frame is abandoned. No resume. The next start begins at address 0.
- FSM:
  - IDLE: start leads to RUN. read_addr and issue_cnt are cleared on that edge.
  - RUN: the handshake of the beat with tlast=1 leads to DONE.
  - DONE: done=1 for one cycle, then leads to IDLE.
  - start outside IDLE is ignored.
- Read issue (combinational):
  - ren = RUN && issue_cnt<DEPTH && (occ + rd_pending − pop) < 2
  - pop = tvalid && tready
- On ren: read_addr and issue_cnt increment. The registered rd_pending is set for the next cycle, along with a last tag when issue_cnt==DEPTH−1.
- After the final issue, read_addr holds DEPTH and issue_cnt holds DEPTH until the next start.
- Capture: when rd_pending=1, the BRAM outputs are written into the buffer tail on that edge, with the last tag.
- Packing, little end first:
  - [15:0]=n, [31:16]=null, [47:32]=ne, [63:48]=e, [79:64]=se
  - [95:80]=s, [111:96]=sw, [127:112]=w, [143:128]=nw
- Output: tvalid=(occ≠0). tdata and tlast come from the buffer head. tlast is the head's last tag.
- AXIS rules:
  - tvalid never drops, and tdata/tlast never change, while tvalid=1 && tready=0.
  - tvalid does not depend combinationally on tready.
- Simultaneous push and pop with occ=1 or 2: occupancy is unchanged and order is preserved. Overflow is impossible by construction of the ren rule.
- Latency: start sampled on edge E0. ren=1 with read_addr=0 in the cycle after E0. tvalid rises after E2.
- Throughput: with tready held 1, beats are back-to-back. The tlast handshake occurs DEPTH−1 cycles after the first beat. done is high in the cycle after the tlast handshake.
- Stall: with tready=0, at most 2 pixels are read ahead. read_addr stalls at 2 when stalled from frame start.
- Width: issue_cnt is ADDRESS_WIDTH bits. DEPTH ≤ 2^ADDRESS_WIDTH−1.

Test Plan:
- Full frame, tready=1, BRAM model returning data = address in every lane:
  - 2500 beats, beat k has every lane = k
  - tlast only on beat 2499
  - first tvalid 2 cycles after start
  - done is a single pulse 1 cycle after the last handshake
  - busy low afterward
- Lane packing: lanes n..nw = 0x1111..0x9999 at address 0 → beat0 tdata = 0x9999_8888_7777_6666_5555_4444_3333_2222_1111; tstrb = 0x3FFFF.
- Backpressure from start: tready=0 for 10 cycles after start → ren pulses exactly twice, read_addr=2, tvalid=1, tdata stable. Release tready → beats 0,1,2… arrive in order with no gaps or duplicates.
- Random tready (50%) over a full frame → exactly 2500 handshakes in order, no tdata change during stalls, one tlast, one done.
- start pulsed during RUN at beat 100 → ignored; the frame completes normally at 2500 beats.
- aresetn low at beat 1000 → tvalid, busy and ren go 0 immediately; read_addr=0. A new start streams from beat 0 with the correct tlast at 2499.
